pooling_stream: RTL and testbench

- Streaming, multi-channel successor to the single-shot pooling block.
- Accepts one CH-wide fixed-point vector per beat over a valid/ready handshake.
- Reduces each channel independently over a runtime-selectable power-of-two sequence length, with max, mean, min or saturating-sum mode.
- Sits between attention/FFN output buffers and the classifier head, pooling token sequences per channel.

---
 rtl/pooling_pkg.sv | 14 +
 rtl/pool_lane.sv | 49 ++++
 rtl/pooling_stream.sv | 74 +++++++
 tb/tb_pooling_stream.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pooling_pkg.sv
// pooling_pkg: shared FSM state and mode encodings plus a width-generic saturation helper
// Ports: none (package)
package pooling_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, ACCUM = 2'b01, DONE = 2'b10} state_t;
   typedef enum logic [1:0] {MAX = 2'b00, MEAN = 2'b01, MIN = 2'b10, SUM = 2'b11} mode_t;
   // v carries an iw-bit signed value; result is clipped to the signed ow-bit range
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int iw, input int ow);
      logic signed [63:0] x, hi, lo;
      x = (v <<< (64 - iw)) >>> (64 - iw);
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return x > hi ? hi : x < lo ? lo : x;
   endfunction
endpackage

// File: rtl/pool_lane.sv
// pool_lane: one channel of the pooling reduction (max, min and wide sum registers)
// Ports: clk, reset (sync, active-high); clear zeroes the lane; load starts a run with d;
//        update folds d into the lane; mode/len_log2 select the result; result is combinational
module pool_lane
   import pooling_pkg::*;
#(
   parameter int IL = 4,
   parameter int FL = 16,
   parameter int MAX_LOG = 6,
   parameter int LW = $clog2(MAX_LOG + 1),
   parameter int AW = IL + FL + MAX_LOG
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    load,
   input  logic                    update,
   input  mode_t                   mode,
   input  logic [LW-1:0]           len_log2,
   input  logic signed [IL+FL-1:0] d,
   output logic signed [IL+FL-1:0] result
);
   localparam int DW = IL + FL;
   logic signed [DW-1:0] mx, mn;
   logic signed [AW-1:0] acc, d_ext;
   assign d_ext = {{(AW - DW){d[DW-1]}}, d};
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         mx <= '0;
         mn <= '0;
         acc <= '0;
      end else if (load) begin
         mx <= d;
         mn <= d;
         acc <= d_ext;
      end else if (update) begin
         mx <= d > mx ? d : mx;
         mn <= d < mn ? d : mn;
         acc <= acc + d_ext;
      end
   end
   // mean is a floor shift truncated to DW bits; sum clips to the DW range
   always_comb begin
      result = mode == MAX ? mx :
               mode == MIN ? mn :
               mode == MEAN ? DW'(acc >>> len_log2) :
               DW'(saturate(64'(acc), AW, DW));
   end
endmodule

// File: rtl/pooling_stream.sv
// pooling_stream: streaming per-channel max/mean/min/saturating-sum pooling over 2^len_log2 beats
// Ports: clk, reset (sync, active-high); im/in_valid/in_ready input beat handshake;
//        mode, len_log2 latched on the first beat; om/out_valid result, released by output_taken;
//        state reports IDLE/ACCUM/DONE
module pooling_stream
   import pooling_pkg::*;
#(
   parameter int IL = 4,
   parameter int FL = 16,
   parameter int CH = 8,
   parameter int MAX_LOG = 6,
   parameter int LW = $clog2(MAX_LOG + 1),
   parameter int AW = IL + FL + MAX_LOG
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [CH-1:0][IL+FL-1:0]     im,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [1:0]                   mode,
   input  logic [LW-1:0]                len_log2,
   input  logic                         output_taken,
   output logic [CH-1:0][IL+FL-1:0]     om,
   output logic                         out_valid,
   output logic [1:0]                   state
);
   localparam int DW = IL + FL;
   localparam int CW = MAX_LOG + 1;
   state_t st, nx;
   mode_t m_q;
   logic [LW-1:0] len_q, len_in;
   logic [CW-1:0] cnt, cnt_nx;
   logic accept, load, update, clear, last;
   logic [CH-1:0][DW-1:0] res;
   assign in_ready = st != DONE;
   assign out_valid = st == DONE;
   assign state = st;
   assign accept = in_valid && in_ready;
   assign load = accept && st == IDLE;
   assign update = accept && st == ACCUM;
   assign clear = st == DONE && output_taken;
   assign len_in = len_log2 > LW'(MAX_LOG) ? LW'(MAX_LOG) : len_log2;
   assign cnt_nx = cnt + 1'b1;
   assign last = cnt_nx == (CW'(1) << len_q);
   always_comb begin
      nx = st;
      if (load) nx = len_in == '0 ? DONE : ACCUM;
      else if (update && last) nx = DONE;
      else if (clear) nx = IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         st <= IDLE;
         cnt <= '0;
         m_q <= MAX;
         len_q <= '0;
      end else begin
         st <= nx;
         if (load) begin
            m_q <= mode_t'(mode);
            len_q <= len_in;
            cnt <= CW'(1);
         end else if (update) cnt <= cnt_nx;
         else if (clear) cnt <= '0;
      end
   end
   for (genvar i = 0; i < CH; i++) begin : g_lane
      pool_lane #(.IL(IL), .FL(FL), .MAX_LOG(MAX_LOG), .LW(LW), .AW(AW)) u_lane (
         .clk(clk), .reset(reset), .clear(clear), .load(load), .update(update),
         .mode(m_q), .len_log2(len_q), .d(im[i]), .result(res[i])
      );
      assign om[i] = st == DONE ? res[i] : '0;
   end
endmodule

// File: tb/tb_pooling_stream.sv
// tb_pooling_stream: directed scoreboard bench for pooling_stream
module tb_pooling_stream;
   import pooling_pkg::*;
   localparam int CH = 8, DW = 20, LW = 3;
   typedef logic [CH-1:0][DW-1:0] vec_t;
   logic clk, reset, in_valid, in_ready, output_taken, out_valid;
   logic [1:0] mode, state;
   logic [LW-1:0] len_log2;
   vec_t im, om;
   vec_t sb[$];
   vec_t beats[64];
   vec_t e1;
   int n_cmp = 0, n_bad = 0;

   pooling_stream dut (
      .clk(clk), .reset(reset), .im(im), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .len_log2(len_log2), .output_taken(output_taken),
      .om(om), .out_valid(out_valid), .state(state)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [CH*DW-1:0] act, input logic [CH*DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t v2(input logic [DW-1:0] a, input logic [DW-1:0] b);
      vec_t v = '0;
      v[0] = a;
      v[1] = b;
      return v;
   endfunction

   always @(negedge clk) begin
      if (out_valid && output_taken) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %h expected none", om);
         end else chk("om_scoreboard", om, sb.pop_front());
      end
   end

   task automatic take(input string nm);
      int k = 0;
      while (!out_valid && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      if (k == 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: got out_valid=0 expected 1", nm);
      end
      output_taken = 1;
      @(posedge clk); #1;
      output_taken = 0;
      chk({nm, "_idle_state"}, state, IDLE);
      chk({nm, "_idle_valid"}, out_valid, 0);
      chk({nm, "_idle_om"}, om, 0);
   endtask

   // mode/len_log2 are scrambled after the first beat to confirm the latched values govern the run
   task automatic run(input logic [1:0] m, input logic [LW-1:0] l, input int n, input vec_t exp,
                      input bit do_take, input string nm);
      for (int i = 0; i < n; i++) begin
         mode = i == 0 ? m : ~m;
         len_log2 = i == 0 ? l : LW'(1);
         im = beats[i];
         in_valid = 1;
         @(posedge clk); #1;
         if (i == n - 2) chk({nm, "_mid_state"}, state, ACCUM);
      end
      in_valid = 0;
      chk({nm, "_done_state"}, state, DONE);
      chk({nm, "_out_valid"}, out_valid, 1);
      chk({nm, "_in_ready"}, in_ready, 0);
      sb.push_back(exp);
      if (do_take) take(nm);
   endtask

   task automatic load_t1();
      beats[0] = v2(20'h10000, 20'hF0000);
      beats[1] = v2(20'hE0000, 20'h20000);
      beats[2] = v2(20'h38000, 20'hC8000);
      beats[3] = v2(20'h04000, 20'hFC000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1; in_valid = 0; output_taken = 0; mode = 0; len_log2 = 0; im = '0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      chk("rst_state", state, IDLE);
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_om", om, 0);

      load_t1();
      run(2'b00, 2, 4, v2(20'h38000, 20'h20000), 1, "max");
      run(2'b01, 2, 4, v2(20'h0B000, 20'hF5000), 1, "mean");
      run(2'b10, 2, 4, v2(20'hE0000, 20'hC8000), 1, "min");

      for (int i = 0; i < 4; i++) begin
         beats[i] = v2(20'h78000, 20'h80000);
         beats[i][2] = 20'h08000;
      end
      e1 = v2(20'h7FFFF, 20'h80000);
      e1[2] = 20'h20000;
      run(2'b11, 2, 4, e1, 1, "sum");

      beats[0] = v2(20'hFFFFF, 20'h0);
      for (int i = 1; i < 4; i++) beats[i] = '0;
      run(2'b01, 2, 4, v2(20'hFFFFF, 20'h0), 1, "mean_floor");

      beats[0] = '0;
      beats[0][3] = 20'h12345;
      run(2'b00, 0, 1, beats[0], 1, "len1");

      for (int i = 0; i < 64; i++) beats[i] = v2(DW'(i), DW'(-i));
      run(2'b01, 7, 64, v2(20'h0001F, 20'hFFFE0), 1, "len64");

      mode = 0; len_log2 = 2; im = v2(20'h70000, 20'h70000); in_valid = 1;
      repeat (2) @(posedge clk);
      #1 in_valid = 0; reset = 1;
      @(posedge clk); #1 reset = 0;
      chk("midrst_state", state, IDLE);
      chk("midrst_valid", out_valid, 0);
      beats[0] = v2(20'h08000, 20'hF0000);
      beats[1] = v2(20'h04000, 20'hE0000);
      beats[2] = v2(20'hF0000, 20'hD0000);
      beats[3] = v2(20'h02000, 20'hC0000);
      run(2'b00, 2, 4, v2(20'h08000, 20'hF0000), 1, "fresh");

      load_t1();
      e1 = v2(20'h38000, 20'h20000);
      run(2'b00, 2, 4, e1, 0, "hold");
      im = v2(20'h7FFFF, 20'h7FFFF); in_valid = 1;
      repeat (5) begin
         @(posedge clk); #1;
         chk("hold_ready", in_ready, 0);
         chk("hold_om", om, e1);
      end
      chk("hold_state", state, DONE);
      output_taken = 1; mode = 0; len_log2 = 0; im = v2(20'h11111, 20'h22222);
      @(posedge clk); #1 output_taken = 0;
      chk("taken_state", state, IDLE);
      sb.push_back(v2(20'h11111, 20'h22222));
      @(posedge clk); #1 in_valid = 0;
      chk("beat0_state", state, DONE);
      take("beat0");

      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
